// File: rtl/mem_pkg.sv
// Shared types for the wait-state memory model.
// Holds the funct3 width codes, FSM states and width helpers.
package mem_pkg;

    typedef enum logic [2:0] {
        WD_B   = 3'b000,
        WD_H   = 3'b001,
        WD_W   = 3'b010,
        WD_D   = 3'b011,
        WD_BU  = 3'b100,
        WD_HU  = 3'b101,
        WD_WU  = 3'b110,
        WD_BAD = 3'b111
    } width_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic [3:0] width_bytes(
        input logic [2:0] w
    );
        logic [3:0] n;
        unique case (w[1:0])
            2'b00:   n = 4'd1;
            2'b01:   n = 4'd2;
            2'b10:   n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    // Doubleword and WU only exist on RV64.
    function automatic logic width_legal(
        input logic [2:0] w,
        input int         xlen
    );
        logic ok;
        unique case (w)
            WD_BAD:       ok = 1'b0;
            WD_D, WD_WU:  ok = (xlen == 64);
            default:      ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/wait_memory_load_extend.sv
// Load data extender: sign/zero extends raw little-endian bytes.
// Ports: raw (XLEN bytes from memory), width (funct3), data (result).
module load_extend
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] raw,
    input  logic [2:0]      width,
    output logic [XLEN-1:0] data
);

    always_comb begin
        data = '0;
        unique case (width)
            WD_B:    data = XLEN'(signed'(raw[7:0]));
            WD_H:    data = XLEN'(signed'(raw[15:0]));
            WD_W:    data = XLEN'(signed'(raw[31:0]));
            WD_D:    data = raw;
            WD_BU:   data = XLEN'(raw[7:0]);
            WD_HU:   data = XLEN'(raw[15:0]);
            WD_WU:   data = XLEN'(raw[31:0]);
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/wait_memory.sv
// Byte-addressed memory with a fixed response latency and fault checks.
// Ports: clock/reset, req_* request channel, resp_* response channel.
module wait_memory
    import mem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_BYTES = 4096,
    parameter int LATENCY     = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_width,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int NB = XLEN / 8;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [7:0] mem [DEPTH_BYTES];

    state_e     state;
    logic [3:0] count;

    logic            a_write;
    logic [2:0]      a_width;
    logic [XLEN-1:0] a_addr;
    logic [XLEN-1:0] a_wdata;

    logic            accept;
    logic            enter_resp;

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign accept     = req_ready && req_valid;

    // With LATENCY = 1 the access happens on the acceptance
    // edge, so it works straight from the request bus.
    generate
        if (LATENCY == 1) begin : g_direct
            assign a_write = req_write;
            assign a_width = req_width;
            assign a_addr  = req_addr;
            assign a_wdata = req_wdata;
            assign enter_resp = accept;
        end else begin : g_capture
            logic            r_write;
            logic [2:0]      r_width;
            logic [XLEN-1:0] r_addr;
            logic [XLEN-1:0] r_wdata;

            always_ff @(posedge clock) begin
                if (accept) begin
                    r_write <= req_write;
                    r_width <= req_width;
                    r_addr  <= req_addr;
                    r_wdata <= req_wdata;
                end
            end

            assign a_write = r_write;
            assign a_width = r_width;
            assign a_addr  = r_addr;
            assign a_wdata = r_wdata;
            assign enter_resp = (state == ST_BUSY)
                             && (count == 4'd0);
        end
    endgenerate

    logic [3:0]      a_size;
    logic [XLEN:0]   a_end;
    logic            a_misal;
    logic            a_fault;
    logic [AW-1:0]   a_idx;

    always_comb begin
        a_size = width_bytes(a_width);
        unique case (a_size)
            4'd1:    a_misal = 1'b0;
            4'd2:    a_misal = a_addr[0];
            4'd4:    a_misal = |a_addr[1:0];
            default: a_misal = |a_addr[2:0];
        endcase
        // One extra bit so addr + size cannot wrap.
        a_end   = {1'b0, a_addr} + (XLEN+1)'(a_size);
        a_fault = !width_legal(a_width, XLEN)
               || a_misal
               || (a_end > (XLEN+1)'(DEPTH_BYTES));
        a_idx   = a_addr[AW-1:0];
    end

    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] ld_data;

    always_comb begin
        raw = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(a_size)) begin
                raw[8*i +: 8] = mem[a_idx + AW'(i)];
            end
        end
    end

    load_extend #(
        .XLEN(XLEN)
    ) u_ext (
        .raw   (raw),
        .width (a_width),
        .data  (ld_data)
    );

    // Storage is never cleared by reset.
    always_ff @(posedge clock) begin
        if (enter_resp && a_write && !a_fault) begin
            for (int i = 0; i < NB; i++) begin
                if (i < int'(a_size)) begin
                    mem[a_idx + AW'(i)] <= a_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            count      <= 4'd0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        count <= CNT_INIT;
                        state <= (LATENCY == 1) ? ST_RESP
                                                : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (count == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (enter_resp) begin
                resp_fault <= a_fault;
                resp_rdata <= (a_fault || a_write) ? '0
                                                   : ld_data;
            end
        end
    end

endmodule

// File: tb/tb_wait_memory.sv
// Self-checking bench for wait_memory (RV32/LAT3 and RV64/LAT4).
// Directed spec cases plus random traffic against a byte-array model.
module tb_wait_memory;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_a, reset_b;
    logic        valid_a, valid_b;
    logic        req_write;
    logic [2:0]  req_width;
    logic [63:0] req_addr, req_wdata;
    logic        resp_ready;

    logic        ready_a, rvalid_a, fault_a;
    logic [31:0] rdata_a;
    logic        ready_b, rvalid_b, fault_b;
    logic [63:0] rdata_b;

    wait_memory #(
        .XLEN(32), .DEPTH_BYTES(4096), .LATENCY(3)
    ) dut_a (
        .clock      (clock),
        .reset      (reset_a),
        .req_valid  (valid_a),
        .req_ready  (ready_a),
        .req_write  (req_write),
        .req_width  (req_width),
        .req_addr   (req_addr[31:0]),
        .req_wdata  (req_wdata[31:0]),
        .resp_valid (rvalid_a),
        .resp_ready (resp_ready),
        .resp_rdata (rdata_a),
        .resp_fault (fault_a)
    );

    wait_memory #(
        .XLEN(64), .DEPTH_BYTES(4096), .LATENCY(4)
    ) dut_b (
        .clock      (clock),
        .reset      (reset_b),
        .req_valid  (valid_b),
        .req_ready  (ready_b),
        .req_write  (req_write),
        .req_width  (req_width),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (rvalid_b),
        .resp_ready (resp_ready),
        .resp_rdata (rdata_b),
        .resp_fault (fault_b)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] model_a [4096];
    logic [7:0] model_b [4096];

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    // Reference: RISC-V load/store semantics on a byte array.
    task automatic model(input int d, input logic wr,
                         input logic [2:0] w,
                         input logic [63:0] addr,
                         input logic [63:0] wd,
                         output logic [63:0] rd,
                         output logic flt);
        int          xlen;
        int          sz;
        logic [64:0] a;
        logic [63:0] v;
        xlen = d ? 64 : 32;
        a = d ? {1'b0, addr} : {33'b0, addr[31:0]};
        case (w)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2, 3'd6: sz = 4;
            3'd3:       sz = 8;
            default:    sz = 0;
        endcase
        if (xlen == 32 && (w == 3'd3 || w == 3'd6)) sz = 0;
        flt = 1'b0;
        if (sz == 0) flt = 1'b1;
        else if (a % sz != 0) flt = 1'b1;
        else if (a + 65'(sz) > 65'd4096) flt = 1'b1;
        rd = '0;
        if (!flt) begin
            if (wr) begin
                for (int i = 0; i < sz; i++) begin
                    if (d) model_b[int'(a[11:0]) + i] = wd[8*i +: 8];
                    else   model_a[int'(a[11:0]) + i] = wd[8*i +: 8];
                end
            end else begin
                v = '0;
                for (int i = 0; i < sz; i++) begin
                    if (d) v = v | (64'(model_b[int'(a[11:0]) + i]) << (8*i));
                    else   v = v | (64'(model_a[int'(a[11:0]) + i]) << (8*i));
                end
                if (w < 3'd4 && v[8*sz-1])
                    v = v | ~((64'h1 << (8*sz)) - 64'h1);
                rd = (xlen == 32) ? {32'b0, v[31:0]} : v;
            end
        end
    endtask

    task automatic txn(input int d, input logic wr,
                       input logic [2:0] w,
                       input logic [63:0] addr,
                       input logic [63:0] wd,
                       output logic [63:0] rd,
                       output logic flt,
                       output int lat);
        int k;
        @(negedge clock);
        req_write = wr;
        req_width = w;
        req_addr  = addr;
        req_wdata = wd;
        if (d) valid_b = 1'b1; else valid_a = 1'b1;
        k = 0;
        while (!(d ? ready_b : ready_a) && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("accept", 64'(d ? ready_b : ready_a), 64'd1);
        @(posedge clock);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        lat = 0;
        while (lat < 30) begin
            @(posedge clock);
            #1;
            lat++;
            if (d ? rvalid_b : rvalid_a) break;
        end
        rd  = d ? rdata_b : {32'b0, rdata_a};
        flt = d ? fault_b : fault_a;
        @(posedge clock);
        #1;
    endtask

    task automatic run(input string tag, input int d,
                       input logic wr, input logic [2:0] w,
                       input logic [63:0] addr,
                       input logic [63:0] wd,
                       output logic [63:0] rd,
                       output logic flt);
        logic [63:0] erd;
        logic        eflt;
        int          lat;
        model(d, wr, w, addr, wd, erd, eflt);
        txn(d, wr, w, addr, wd, rd, flt, lat);
        chk({tag, " latency"}, 64'(lat), d ? 64'd4 : 64'd3);
        chk({tag, " rdata"}, rd, erd);
        chk({tag, " fault"}, 64'(flt), 64'(eflt));
    endtask

    initial begin
        logic [63:0] rd, erd, ad, wd;
        logic        flt, eflt;
        logic [2:0]  w;
        logic        wr;
        int          cnt, lat;

        reset_a = 1'b1;
        reset_b = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        req_write = 1'b0;
        req_width = 3'd0;
        req_addr  = '0;
        req_wdata = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            model_a[i] = 8'($urandom);
            model_b[i] = 8'($urandom);
            dut_a.mem[i] = model_a[i];
            dut_b.mem[i] = model_b[i];
        end
        repeat (2) @(negedge clock);
        chk("reset rvalid_a", 64'(rvalid_a), 64'd0);
        chk("reset rdata_a", 64'(rdata_a), 64'd0);
        chk("reset fault_a", 64'(fault_a), 64'd0);
        chk("reset rvalid_b", 64'(rvalid_b), 64'd0);
        chk("reset rdata_b", rdata_b, 64'd0);
        reset_a = 1'b0;
        reset_b = 1'b0;
        #1;
        chk("post reset ready_a", 64'(ready_a), 64'd1);
        chk("post reset ready_b", 64'(ready_b), 64'd1);

        run("sw 10", 0, 1, 3'd2, 64'h10, 64'hDEADBEEF, rd, flt);
        chk("sw 10 rdata0", rd, 64'd0);
        run("lw 10", 0, 0, 3'd2, 64'h10, 64'h0, rd, flt);
        chk("lw 10 value", rd, 64'hDEADBEEF);

        @(negedge clock);
        dut_a.mem[32'h20] = 8'h80;
        model_a[32'h20]   = 8'h80;
        run("lb 20", 0, 0, 3'd0, 64'h20, 64'h0, rd, flt);
        chk("lb 20 value", rd, 64'hFFFFFF80);
        run("lbu 20", 0, 0, 3'd4, 64'h20, 64'h0, rd, flt);
        chk("lbu 20 value", rd, 64'h80);

        run("lh 21", 0, 0, 3'd1, 64'h21, 64'h0, rd, flt);
        chk("lh 21 fault", 64'(flt), 64'd1);
        run("sw ffe", 0, 1, 3'd2, 64'hFFE, 64'h11223344, rd, flt);
        chk("sw ffe fault", 64'(flt), 64'd1);
        chk("ffe kept", 64'(dut_a.mem[32'hFFE]), 64'(model_a[32'hFFE]));
        chk("fff kept", 64'(dut_a.mem[32'hFFF]), 64'(model_a[32'hFFF]));
        run("ld on rv32", 0, 0, 3'd3, 64'h8, 64'h0, rd, flt);
        chk("ld rv32 fault", 64'(flt), 64'd1);

        // Response back-pressure.
        model(0, 0, 3'd2, 64'h10, 64'h0, erd, eflt);
        @(negedge clock);
        resp_ready = 1'b0;
        req_write = 1'b0;
        req_width = 3'd2;
        req_addr  = 64'h10;
        valid_a = 1'b1;
        @(posedge clock);
        #1;
        valid_a = 1'b0;
        lat = 0;
        while (lat < 30) begin
            @(posedge clock);
            #1;
            lat++;
            if (rvalid_a) break;
        end
        chk("bp latency", 64'(lat), 64'd3);
        for (int i = 0; i < 5; i++) begin
            chk("bp rvalid", 64'(rvalid_a), 64'd1);
            chk("bp rdata", 64'(rdata_a), erd);
            chk("bp fault", 64'(fault_a), 64'(eflt));
            chk("bp ready", 64'(ready_a), 64'd0);
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("bp release ready", 64'(ready_a), 64'd1);
        chk("bp release rvalid", 64'(rvalid_a), 64'd0);

        // Reset during an in-flight store.
        @(negedge clock);
        req_write = 1'b1;
        req_width = 3'd2;
        req_addr  = 64'h40;
        req_wdata = 64'h12345678;
        valid_b = 1'b1;
        @(posedge clock);
        #1;
        valid_b = 1'b0;
        @(posedge clock);
        #1;
        reset_b = 1'b1;
        #1;
        chk("rst rvalid", 64'(rvalid_b), 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_b = 1'b0;
        #1;
        chk("rst ready after", 64'(ready_b), 64'd1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            if (rvalid_b) cnt++;
        end
        chk("rst no resp", 64'(cnt), 64'd0);
        for (int i = 0; i < 4; i++)
            chk("rst mem kept", 64'(dut_b.mem[12'h40 + i]),
                64'(model_b[32'h40 + i]));

        run("sd 8", 1, 1, 3'd3, 64'h8, 64'h8000000000000001, rd, flt);
        run("lwu c", 1, 0, 3'd6, 64'hC, 64'h0, rd, flt);
        chk("lwu c value", rd, 64'h0000000080000000);
        run("lw c", 1, 0, 3'd2, 64'hC, 64'h0, rd, flt);
        chk("lw c value", rd, 64'hFFFFFFFF80000000);
        run("ld 8", 1, 0, 3'd3, 64'h8, 64'h0, rd, flt);
        chk("ld 8 value", rd, 64'h8000000000000001);
        run("bad width", 1, 0, 3'd7, 64'h8, 64'h0, rd, flt);
        run("sd ff8", 1, 1, 3'd3, 64'hFF8, 64'h0123456789ABCDEF, rd, flt);
        run("ld ff8", 1, 0, 3'd3, 64'hFF8, 64'h0, rd, flt);
        run("huge addr", 1, 0, 3'd0, 64'hFFFFFFFFFFFFFFFF, 64'h0, rd, flt);

        for (int n = 0; n < 160; n++) begin
            int d;
            int r;
            d  = n % 2;
            wr = 1'($urandom);
            w  = 3'($urandom);
            r  = $urandom_range(0, 7);
            if (r == 0)
                ad = {32'($urandom), 32'($urandom)};
            else if (r == 1)
                ad = 64'(4096 - $urandom_range(1, 8));
            else begin
                ad = 64'($urandom_range(0, 4095)) & ~64'h7;
                if (r == 2) ad = ad | 64'($urandom_range(0, 7));
            end
            wd = {32'($urandom), 32'($urandom)};
            run("random", d, wr, w, ad, wd, rd, flt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wait_memory.md
WAIT_MEMORY -- requirements
Module: wait_memory

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH_BYTES, default 4096, byte capacity; power of two.
REQ-003 SHALL have parameter LATENCY, default 2, clock edges from request acceptance to response valid; legal values 1 to 15.
REQ-004 SHALL have port clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  block can accept a request.
REQ-008 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_width  input  3  RISC-V funct3 access width and extension code.
REQ-010 SHALL have port req_addr  input  XLEN  byte address.
REQ-011 SHALL have port req_wdata  input  XLEN  store data, low bytes used.
REQ-012 SHALL have port resp_valid  output  1  response present.
REQ-013 SHALL have port resp_ready  input  1  consumer accepts response.
REQ-014 SHALL have port resp_rdata  output  XLEN  extended load data; 0 for stores and faults.
REQ-015 SHALL have port resp_fault  output  1  access faulted.

Function
REQ-016 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE; req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-017 SHALL accept a request on a rising edge with req_valid && req_ready; all request fields are captured at that edge.
REQ-018 SHALL load a down-counter with LATENCY-1 at acceptance and decrement it once per cycle in BUSY; LATENCY = 1 goes directly IDLE -> RESP.
REQ-019 SHALL enter RESP when the counter reaches 0, so resp_valid rises exactly LATENCY edges after acceptance.
REQ-020 SHALL perform the memory access (store commit or load read) on the edge entering RESP, not at acceptance.
REQ-021 SHALL hold resp_rdata and resp_fault stable while resp_valid && !resp_ready.
REQ-022 SHALL return to IDLE on the edge with resp_valid && resp_ready; no new request is accepted on that same edge.
REQ-023 SHALL decode req_width as follows: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU; 011 and 110 are legal only when XLEN = 64; 111 is always illegal.
REQ-024 SHALL sign-extend B, H and W (XLEN = 64) loads and zero-extend BU, HU and WU loads to XLEN.
REQ-025 SHALL use little-endian byte order; a store writes only its size in bytes, taken from the low bytes of req_wdata.
REQ-026 SHALL raise resp_fault for: illegal width; an address not a multiple of the access size; addr + size > DEPTH_BYTES, evaluated without overflow.
REQ-027 SHALL leave memory unmodified on a faulting store and return resp_rdata = 0 on any fault.
REQ-028 SHALL hold storage in a byte array named mem[DEPTH_BYTES], 8 bits per entry, reachable hierarchically for testbench backdoor load and peek.

Reset
REQ-029 SHALL, on reset assertion at any time, force the FSM to IDLE, the counter to 0, resp_valid = 0, resp_rdata = 0 and resp_fault = 0.
REQ-030 SHALL discard an in-flight request on reset; a store not yet committed never reaches mem.
REQ-031 SHALL not clear mem contents on reset.
REQ-032 SHALL drive req_ready = 1 on the first cycle after reset deasserts.

Structure
REQ-033 SHALL place in package mem_pkg: the width enum (funct3 codes) and the FSM state enum.
REQ-034 SHALL use one combinational sub-module, load_extend, which takes raw bytes and width and returns the extended XLEN result.

Verification
REQ-035 SHALL verify: LATENCY = 3, SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_valid exactly 3 edges after each acceptance; rdata 0xDEADBEEF; fault 0.
REQ-036 SHALL verify: mem[0x20] = 0x80 via backdoor, LB @0x20 -> 0xFFFFFF80; LBU @0x20 -> 0x00000080.
REQ-037 SHALL verify: LH @0x21 -> fault 1, rdata 0; SW @0xFFE with DEPTH_BYTES = 4096 -> fault 1, mem[0xFFE..0xFFF] unchanged.
REQ-038 SHALL verify: resp_ready held 0 for 5 cycles -> resp_valid, rdata and fault stable; req_ready = 0 throughout; resp_ready = 1 -> IDLE on the next edge.
REQ-039 SHALL verify: SW 0x12345678 @0x40, reset asserted one cycle after acceptance with LATENCY = 4 -> resp_valid never rises; mem[0x40..0x43] keeps its prior value; req_ready = 1 after reset.
REQ-040 SHALL verify: XLEN = 32 with width 011 -> fault 1; XLEN = 64, SD 0x8000000000000001 @0x8, then LWU @0xC -> 0x0000000080000000.
